// File: rtl/tlb_op_sched_if.sv
// Handshake and strobe bundle between the WB-side TLB op issuer, the EXE s1
// requester and the TLB op scheduler.
interface tlb_op_sched_if #(
  parameter int IDXW = 4
);
  logic            op_valid;
  logic            op_ready;
  logic [2:0]      op_code;
  logic [4:0]      inv_op;
  logic [IDXW-1:0] csr_index;
  logic            flush;
  logic            exe_req;
  logic            exe_gnt;
  logic [1:0]      s1_owner;
  logic            tlbsrch_en;
  logic            tlbrd_we;
  logic            tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic            invtlb_valid;
  logic [4:0]      invtlb_op_o;
  logic            busy;
  logic            done;
  logic            op_err;

  modport master (
    output op_valid, op_code, inv_op, csr_index, flush, exe_req,
    input  op_ready, exe_gnt, s1_owner, tlbsrch_en, tlbrd_we, tlb_we,
           tlb_w_index, invtlb_valid, invtlb_op_o, busy, done, op_err
  );

  modport slave (
    input  op_valid, op_code, inv_op, csr_index, flush, exe_req,
    output op_ready, exe_gnt, s1_owner, tlbsrch_en, tlbrd_we, tlb_we,
           tlb_w_index, invtlb_valid, invtlb_op_o, busy, done, op_err
  );
endinterface

// File: rtl/tlb_op_sched.sv
// Sequences WB-issued TLB maintenance ops into one-cycle TLB/CSR strobes and
// arbitrates the shared s1 search port against EXE address translation.
module tlb_op_sched #(
  parameter int         TLBNUM    = 16,
  parameter int         IDXW      = $clog2(TLBNUM),
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  tlb_op_sched_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SRCH  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    INV   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t          state_reg, state_next;
  logic [7:0]      lfsr_reg, lfsr_next;
  logic            err_reg, err_next;
  logic [IDXW-1:0] w_index_reg;
  logic [4:0]      inv_op_reg;
  logic            accept;
  logic [1:0]      s1_owner_w;

  assign accept    = bus.op_valid && bus.op_ready;
  assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      lfsr_reg    <= LFSR_SEED;
      err_reg     <= 1'b0;
      w_index_reg <= '0;
      inv_op_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      err_reg   <= err_next;
      if (accept) begin
        inv_op_reg  <= bus.inv_op;
        // fill index is the LFSR value seen on the accept edge, i.e. as WRITE is entered
        w_index_reg <= (bus.op_code == OP_FILL) ? lfsr_reg[IDXW-1:0] : bus.csr_index;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          err_next = 1'b0;
          case (bus.op_code)
            OP_SRCH:       state_next = SRCH;
            OP_RD:         state_next = READ;
            OP_WR, OP_FILL: state_next = WRITE;
            OP_INV: begin
              if (bus.inv_op <= 5'd6) begin
                state_next = INV;
              end else begin
                state_next = DONE;
                err_next   = 1'b1;
              end
            end
            default: begin
              state_next = DONE;
              err_next   = 1'b1;
            end
          endcase
        end
      end
      SRCH, READ, WRITE, INV: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore decode: strobes are one-hot by construction since each maps to one state.
  always_comb begin
    s1_owner_w       = 2'd0;
    bus.tlbsrch_en   = 1'b0;
    bus.tlbrd_we     = 1'b0;
    bus.tlb_we       = 1'b0;
    bus.invtlb_valid = 1'b0;
    bus.done         = 1'b0;
    case (state_reg)
      SRCH: begin
        s1_owner_w     = 2'd1;
        bus.tlbsrch_en = 1'b1;
      end
      READ:  bus.tlbrd_we = 1'b1;
      WRITE: bus.tlb_we   = 1'b1;
      INV: begin
        s1_owner_w       = 2'd2;
        bus.invtlb_valid = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.s1_owner    = s1_owner_w;
  assign bus.exe_gnt     = bus.exe_req && (s1_owner_w == 2'd0);
  assign bus.op_ready    = (state_reg == IDLE) && !bus.flush && !reset;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.op_err      = bus.done && err_reg;
  assign bus.tlb_w_index = w_index_reg;
  assign bus.invtlb_op_o = inv_op_reg;

endmodule

// File: tb/tb_tlb_op_sched.sv
// Directed bench for tlb_op_sched: table of single ops plus hand-written
// sequences for fill indices, flush, back-to-back and mid-op reset.
module tb_tlb_op_sched;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] lfsr_model;

  tlb_op_sched_if #(.IDXW(4)) bus ();

  tlb_op_sched #(.TLBNUM(16), .IDXW(4), .LFSR_SEED(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference LFSR: x^8+x^6+x^5+x^4+1, advancing every non-reset cycle.
  always @(posedge clk) begin
    if (reset) lfsr_model <= 8'hA5;
    else       lfsr_model <= {lfsr_model[6:0], lfsr_model[7] ^ lfsr_model[5] ^ lfsr_model[4] ^ lfsr_model[3]};
  end

  typedef struct {
    string      name;
    logic [2:0] code;
    logic [4:0] inv;
    logic [3:0] idx;
    logic       err;
    logic [1:0] s1;
    logic       srch;
    logic       rd;
    logic       we;
    logic       inv_v;
    logic       gnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.op_code   = v.code;
    bus.inv_op    = v.inv;
    bus.csr_index = v.idx;
    bus.exe_req   = 1'b1;
    bus.op_valid  = 1'b1;
    #1;
    chk({v.name, ".op_ready"}, 32'(bus.op_ready), 32'd1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    if (v.err) begin
      chk({v.name, ".done"}, 32'(bus.done), 32'd1);
      chk({v.name, ".op_err"}, 32'(bus.op_err), 32'd1);
      chk({v.name, ".strobes"}, {28'd0, bus.tlbsrch_en, bus.tlbrd_we, bus.tlb_we, bus.invtlb_valid}, 32'd0);
    end else begin
      chk({v.name, ".s1_owner"}, 32'(bus.s1_owner), 32'(v.s1));
      chk({v.name, ".strobes"}, {28'd0, bus.tlbsrch_en, bus.tlbrd_we, bus.tlb_we, bus.invtlb_valid},
          {28'd0, v.srch, v.rd, v.we, v.inv_v});
      chk({v.name, ".exe_gnt"}, 32'(bus.exe_gnt), 32'(v.gnt));
      chk({v.name, ".early_done"}, 32'(bus.done), 32'd0);
      if (v.we)    chk({v.name, ".tlb_w_index"}, 32'(bus.tlb_w_index), 32'(v.idx));
      if (v.inv_v) chk({v.name, ".invtlb_op_o"}, 32'(bus.invtlb_op_o), 32'(v.inv));
      @(negedge clk);
      chk({v.name, ".done"}, 32'(bus.done), 32'd1);
      chk({v.name, ".op_err"}, 32'(bus.op_err), 32'd0);
      chk({v.name, ".done_gnt"}, 32'(bus.exe_gnt), 32'd1);
    end
    @(negedge clk);
    chk({v.name, ".ready_again"}, 32'(bus.op_ready), 32'd1);
    $display("op %s code=%0d inv=%0d idx=%0d done", v.name, v.code, v.inv, v.idx);
  endtask

  task automatic do_fill(input int n, input int gap);
    logic [3:0] exp_idx;
    int         waited;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    waited = 0;
    while (!bus.op_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    bus.op_code  = 3'd3;
    bus.op_valid = 1'b1;
    #1;
    chk("fill.op_ready", 32'(bus.op_ready), 32'd1);
    chk("fill.lfsr_nonzero", 32'(dut.lfsr_reg != 8'd0), 32'd1);
    chk("fill.lfsr_model", 32'(dut.lfsr_reg), 32'(lfsr_model));
    exp_idx = lfsr_model[3:0];
    @(negedge clk);
    bus.op_valid = 1'b0;
    chk("fill.tlb_we", 32'(bus.tlb_we), 32'd1);
    chk("fill.tlb_w_index", 32'(bus.tlb_w_index), 32'(exp_idx));
    @(negedge clk);
    chk("fill.done", 32'(bus.done), 32'd1);
    $display("fill %0d gap=%0d index=%0d expected=%0d", n, gap, bus.tlb_w_index, exp_idx);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset         = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_code   = 3'd0;
    bus.inv_op    = 5'd0;
    bus.csr_index = 4'd0;
    bus.flush     = 1'b0;
    bus.exe_req   = 1'b0;

    vecs[0] = '{"srch",    3'd0, 5'd0, 4'd0,  1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"rd",      3'd1, 5'd0, 4'd3,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"wr9",     3'd2, 5'd0, 4'd9,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"wr15",    3'd2, 5'd0, 4'd15, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"inv5",    3'd4, 5'd5, 4'd0,  1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"inv6",    3'd4, 5'd6, 4'd0,  1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{"inv7",    3'd4, 5'd7, 4'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{"rsvd5",   3'd5, 5'd0, 4'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{"rsvd7",   3'd7, 5'd0, 4'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.op_ready", 32'(bus.op_ready), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.op_err", 32'(bus.op_err), 32'd0);
    chk("rst.s1_owner", 32'(bus.s1_owner), 32'd0);
    chk("rst.strobes", {28'd0, bus.tlbsrch_en, bus.tlbrd_we, bus.tlb_we, bus.invtlb_valid}, 32'd0);
    chk("rst.lfsr", 32'(dut.lfsr_reg), 32'hA5);
    reset = 1'b0;
    bus.exe_req = 1'b1;
    #1;
    chk("idle.exe_gnt", 32'(bus.exe_gnt), 32'd1);
    $display("reset state checked");

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Fill indices against the reference LFSR, random spacing
    for (int i = 0; i < 20; i++) do_fill(i, int'($urandom_range(0, 3)));

    // op_valid together with flush: not accepted
    @(negedge clk);
    bus.op_code  = 3'd1;
    bus.op_valid = 1'b1;
    bus.flush    = 1'b1;
    #1;
    chk("flush.op_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    chk("flush.idle", 32'(bus.busy), 32'd0);
    chk("flush.no_rd", 32'(bus.tlbrd_we), 32'd0);
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    $display("flush with op_valid: op not accepted");

    // flush during SRCH does not abort
    @(negedge clk);
    bus.op_code  = 3'd0;
    bus.op_valid = 1'b1;
    #1;
    chk("flush_srch.accept", 32'(bus.op_ready), 32'd1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.flush    = 1'b1;
    #1;
    chk("flush_srch.tlbsrch_en", 32'(bus.tlbsrch_en), 32'd1);
    @(negedge clk);
    chk("flush_srch.done", 32'(bus.done), 32'd1);
    bus.flush = 1'b0;
    $display("flush during srch: op completed");

    // Back-to-back: second op held while busy
    @(negedge clk);
    bus.op_code  = 3'd1;
    bus.op_valid = 1'b1;
    #1;
    chk("b2b.first_ready", 32'(bus.op_ready), 32'd1);
    @(negedge clk);
    bus.op_code = 3'd0;
    chk("b2b.busy_ready", 32'(bus.op_ready), 32'd0);
    chk("b2b.tlbrd_we", 32'(bus.tlbrd_we), 32'd1);
    @(negedge clk);
    chk("b2b.done_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    chk("b2b.second_ready", 32'(bus.op_ready), 32'd1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    chk("b2b.second_srch", 32'(bus.tlbsrch_en), 32'd1);
    @(negedge clk);
    chk("b2b.second_done", 32'(bus.done), 32'd1);
    $display("back-to-back rd then srch completed");

    // Reset in the middle of a write
    @(negedge clk);
    bus.op_code   = 3'd2;
    bus.csr_index = 4'd6;
    bus.op_valid  = 1'b1;
    #1;
    chk("rst_mid.accept", 32'(bus.op_ready), 32'd1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    chk("rst_mid.in_write", 32'(bus.tlb_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid.busy", 32'(bus.busy), 32'd0);
    chk("rst_mid.tlb_we", 32'(bus.tlb_we), 32'd0);
    chk("rst_mid.done", 32'(bus.done), 32'd0);
    chk("rst_mid.lfsr", 32'(dut.lfsr_reg), 32'hA5);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid.no_late_done", 32'(bus.done), 32'd0);
    $display("reset during write: returned to idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
